// File: rtl/parc_core_scoreboard_param_pkg.sv
// Shared encodings and helpers for the PARC issue scoreboard.
// Optional flush support is enabled by defining PARC_SB_FLUSH_EN.
package parc_sb_pkg;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_MEM  = 2'd2,
    FU_MUL  = 2'd3
  } fu_e;

  localparam int BYP_RF    = 0;
  localparam int LAT_MAX_W = 16;

  // Writeback and ROB bypass selects sit just above the FU encodings.
  function automatic int byp_wb(input int num_fu);
    return num_fu + 1;
  endfunction

  function automatic int byp_rob(input int num_fu);
    return num_fu + 2;
  endfunction

  // Frozen stages hold their bit; all other bits move one stage toward writeback.
  function automatic logic [LAT_MAX_W-1:0] lat_shift(input logic [LAT_MAX_W-1:0] lat,
                                                    input logic [LAT_MAX_W-1:0] stalls);
    return (lat & stalls) | ((lat & ~stalls) >> 1);
  endfunction

endpackage

// File: rtl/parc_core_scoreboard_param_if.sv
// Issue/decode/commit bundle between the PARC pipeline control and the scoreboard.
// The flush signal exists only when PARC_SB_FLUSH_EN is defined.
interface parc_core_scoreboard_param_if #(
    parameter int NUM_REGS   = 32,
    parameter int NUM_FU     = 3,
    parameter int LAT_W      = 5,
    parameter int ROB_SLOT_W = 4
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int FU_W  = $clog2(NUM_FU + 1);
    localparam int SEL_W = $clog2(NUM_FU + 3);

`ifdef PARC_SB_FLUSH_EN
    logic                  flush;
`endif
    logic [REG_W-1:0]      src0;
    logic [REG_W-1:0]      src1;
    logic                  src0_en;
    logic                  src1_en;
    logic [REG_W-1:0]      dst;
    logic                  dst_en;
    logic [FU_W-1:0]       func_unit;
    logic [LAT_W-1:0]      latency;
    logic                  inst_val_Ihl;
    logic                  inst_val_Dhl;
    logic [LAT_W-1:0]      stalls;
    logic [ROB_SLOT_W-1:0] rob_alloc_slot;
    logic [ROB_SLOT_W-1:0] rob_commit_slot;
    logic                  rob_commit_wen;
    logic [REG_W-1:0]      src0_byp_Dhl;
    logic                  src0_byp_en_Dhl;
    logic [REG_W-1:0]      src1_byp_Dhl;
    logic                  src1_byp_en_Dhl;
    logic [SEL_W-1:0]      src0_byp_mux_sel;
    logic [SEL_W-1:0]      src1_byp_mux_sel;
    logic [ROB_SLOT_W-1:0] src0_byp_rob_slot;
    logic [ROB_SLOT_W-1:0] src1_byp_rob_slot;
    logic                  stall_hazard_Ihl;
    logic                  stall_hazard_Dhl;
    logic [FU_W-1:0]       wb_mux_sel;

    modport master (
`ifdef PARC_SB_FLUSH_EN
        output flush,
`endif
        output src0, src1, src0_en, src1_en, dst, dst_en, func_unit, latency,
        output inst_val_Ihl, inst_val_Dhl, stalls, rob_alloc_slot,
        output rob_commit_slot, rob_commit_wen,
        output src0_byp_Dhl, src0_byp_en_Dhl, src1_byp_Dhl, src1_byp_en_Dhl,
        input  src0_byp_mux_sel, src1_byp_mux_sel, src0_byp_rob_slot, src1_byp_rob_slot,
        input  stall_hazard_Ihl, stall_hazard_Dhl, wb_mux_sel
    );

    modport slave (
`ifdef PARC_SB_FLUSH_EN
        input  flush,
`endif
        input  src0, src1, src0_en, src1_en, dst, dst_en, func_unit, latency,
        input  inst_val_Ihl, inst_val_Dhl, stalls, rob_alloc_slot,
        input  rob_commit_slot, rob_commit_wen,
        input  src0_byp_Dhl, src0_byp_en_Dhl, src1_byp_Dhl, src1_byp_en_Dhl,
        output src0_byp_mux_sel, src1_byp_mux_sel, src0_byp_rob_slot, src1_byp_rob_slot,
        output stall_hazard_Ihl, stall_hazard_Dhl, wb_mux_sel
    );

endinterface

// File: rtl/parc_core_scoreboard_param_resv_vec.sv
// Per-FU writeback reservation shifter: one-hot bits walk toward writeback unless frozen.
// The clear input is the scoreboard flush (tied low when PARC_SB_FLUSH_EN is undefined).
module parc_sb_resv_vec
    import parc_sb_pkg::*;
#(
    parameter int LAT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [LAT_W-1:0] latency,
    input  logic [LAT_W-1:0] stalls,
    output logic [LAT_W-1:0] resv
);

    logic [LAT_W-1:0] resv_q;
    logic [LAT_W-1:0] resv_d;

    always_comb begin
        resv_d = LAT_W'(lat_shift(LAT_MAX_W'(resv_q), LAT_MAX_W'(stalls)));
        if (load) begin
            resv_d = resv_d | latency;
        end
        if (clear) begin
            resv_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resv_q <= '0;
        end else begin
            resv_q <= resv_d;
        end
    end

    assign resv = resv_q;

endmodule

// File: rtl/parc_core_scoreboard_param.sv
// PARC issue scoreboard: per-register pending/latency/FU/ROB-slot tracking plus per-FU writeback reservations.
// Define PARC_SB_FLUSH_EN to add a flush input that clears all pending state.
module parc_core_scoreboard_param
    import parc_sb_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int NUM_FU     = 3,
    parameter int LAT_W      = 5,
    parameter int BYP_BIT    = 2,
    parameter int ROB_SLOT_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    parc_core_scoreboard_param_if.slave  sb
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int FU_W  = $clog2(NUM_FU + 1);
    localparam int SEL_W = $clog2(NUM_FU + 3);

    logic                  pending_q [NUM_REGS];
    logic                  pending_d [NUM_REGS];
    logic [LAT_W-1:0]      lat_q     [NUM_REGS];
    logic [LAT_W-1:0]      lat_d     [NUM_REGS];
    logic [FU_W-1:0]       fu_q      [NUM_REGS];
    logic [FU_W-1:0]       fu_d      [NUM_REGS];
    logic [ROB_SLOT_W-1:0] slot_q    [NUM_REGS];
    logic [ROB_SLOT_W-1:0] slot_d    [NUM_REGS];

    logic [LAT_W-1:0]      resv      [NUM_FU];
    logic                  resv_load [NUM_FU];

    logic flush_w;
    logic src0_ok, src1_ok, wb_conflict, accept;
    logic src0_dok, src1_dok;

`ifdef PARC_SB_FLUSH_EN
    assign flush_w = sb.flush;
`else
    assign flush_w = 1'b0;
`endif

    // A producer is bypassable once its remaining latency is below BYP_BIT.
    function automatic logic src_ready(input logic en, input logic [REG_W-1:0] r,
                                       input logic pend, input logic [LAT_W-1:0] lat);
        return !en || (r == '0) || !pend || (lat[LAT_W-1:BYP_BIT] == '0);
    endfunction

    function automatic logic [SEL_W-1:0] byp_sel(input logic [REG_W-1:0] r, input logic pend,
                                                 input logic [LAT_W-1:0] lat,
                                                 input logic [FU_W-1:0] fu);
        if (!pend || (r == '0)) return SEL_W'(BYP_RF);
        if (lat == '0)          return SEL_W'(byp_rob(NUM_FU));
        if (lat == LAT_W'(1))   return SEL_W'(byp_wb(NUM_FU));
        return SEL_W'(fu);
    endfunction

    always_comb begin
        src0_ok     = src_ready(sb.src0_en, sb.src0, pending_q[sb.src0], lat_q[sb.src0]);
        src1_ok     = src_ready(sb.src1_en, sb.src1, pending_q[sb.src1], lat_q[sb.src1]);
        wb_conflict = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (((resv[f] >> 1) & sb.latency) != '0) begin
                wb_conflict = 1'b1;
            end
        end
        accept = sb.inst_val_Ihl && src0_ok && src1_ok && !wb_conflict && !flush_w;
        for (int f = 0; f < NUM_FU; f++) begin
            resv_load[f] = accept && (sb.func_unit == FU_W'(f + 1));
        end
    end

    // Decode-side hazard and bypass selects look at the decode source registers.
    always_comb begin
        src0_dok = src_ready(sb.src0_byp_en_Dhl, sb.src0_byp_Dhl,
                             pending_q[sb.src0_byp_Dhl], lat_q[sb.src0_byp_Dhl]);
        src1_dok = src_ready(sb.src1_byp_en_Dhl, sb.src1_byp_Dhl,
                             pending_q[sb.src1_byp_Dhl], lat_q[sb.src1_byp_Dhl]);
        sb.stall_hazard_Ihl  = !accept;
        sb.stall_hazard_Dhl  = !(sb.inst_val_Dhl && src0_dok && src1_dok);
        sb.src0_byp_mux_sel  = byp_sel(sb.src0_byp_Dhl, pending_q[sb.src0_byp_Dhl],
                                       lat_q[sb.src0_byp_Dhl], fu_q[sb.src0_byp_Dhl]);
        sb.src1_byp_mux_sel  = byp_sel(sb.src1_byp_Dhl, pending_q[sb.src1_byp_Dhl],
                                       lat_q[sb.src1_byp_Dhl], fu_q[sb.src1_byp_Dhl]);
        sb.src0_byp_rob_slot = slot_q[sb.src0_byp_Dhl];
        sb.src1_byp_rob_slot = slot_q[sb.src1_byp_Dhl];
        sb.wb_mux_sel        = FU_W'(FU_NONE);
        for (int f = NUM_FU - 1; f >= 0; f--) begin
            if (resv[f][1]) begin
                sb.wb_mux_sel = FU_W'(f + 1);
            end
        end
    end

    // A fresh accept to a register wins over a commit of its old producer.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
            lat_d[r]     = LAT_W'(lat_shift(LAT_MAX_W'(lat_q[r]), LAT_MAX_W'(sb.stalls)));
            fu_d[r]      = fu_q[r];
            slot_d[r]    = slot_q[r];
            if (sb.rob_commit_wen && (slot_q[r] == sb.rob_commit_slot)) begin
                pending_d[r] = 1'b0;
            end
            if (flush_w) begin
                pending_d[r] = 1'b0;
                lat_d[r]     = '0;
            end else if (accept && sb.dst_en && (sb.dst == REG_W'(r)) && (r != 0)) begin
                pending_d[r] = 1'b1;
                lat_d[r]     = sb.latency;
                fu_d[r]      = sb.func_unit;
                slot_d[r]    = sb.rob_alloc_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '{default: '0};
            lat_q     <= '{default: '0};
            fu_q      <= '{default: '0};
            slot_q    <= '{default: '0};
        end else begin
            pending_q <= pending_d;
            lat_q     <= lat_d;
            fu_q      <= fu_d;
            slot_q    <= slot_d;
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_resv
        parc_sb_resv_vec #(.LAT_W(LAT_W)) u_resv (
            .clk     (clk),
            .reset   (reset),
            .clear   (flush_w),
            .load    (resv_load[f]),
            .latency (sb.latency),
            .stalls  (sb.stalls),
            .resv    (resv[f])
        );
    end

    a_lat_nonzero: assert property (@(posedge clk) disable iff (reset)
                                    accept |-> (sb.latency != '0));

endmodule

// File: tb/tb_parc_core_scoreboard_param.sv
// Directed bench for the PARC scoreboard: RAW gating, bypass selects, writeback conflicts, commit, reset, flush.
// Flush scenario is compiled only when PARC_SB_FLUSH_EN is defined.
module tb_parc_core_scoreboard_param;
    import parc_sb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    parc_core_scoreboard_param_if #(.NUM_REGS(32), .NUM_FU(3), .LAT_W(5), .ROB_SLOT_W(4)) sb_if ();

    parc_core_scoreboard_param #(
        .NUM_REGS(32), .NUM_FU(3), .LAT_W(5), .BYP_BIT(2), .ROB_SLOT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
`ifdef PARC_SB_FLUSH_EN
        sb_if.flush = 1'b0;
`endif
        sb_if.src0 = '0;            sb_if.src1 = '0;
        sb_if.src0_en = 1'b0;       sb_if.src1_en = 1'b0;
        sb_if.dst = '0;             sb_if.dst_en = 1'b0;
        sb_if.func_unit = '0;       sb_if.latency = '0;
        sb_if.inst_val_Ihl = 1'b0;  sb_if.inst_val_Dhl = 1'b0;
        sb_if.stalls = '0;          sb_if.rob_alloc_slot = '0;
        sb_if.rob_commit_slot = '0; sb_if.rob_commit_wen = 1'b0;
        sb_if.src0_byp_Dhl = '0;    sb_if.src0_byp_en_Dhl = 1'b0;
        sb_if.src1_byp_Dhl = '0;    sb_if.src1_byp_en_Dhl = 1'b0;
    endtask

    task automatic issue(input int dst, input int fu, input logic [4:0] lat, input int slot);
        sb_if.inst_val_Ihl   = 1'b1;
        sb_if.dst            = 5'(dst);
        sb_if.dst_en         = 1'b1;
        sb_if.func_unit      = 2'(fu);
        sb_if.latency        = lat;
        sb_if.rob_alloc_slot = 4'(slot);
    endtask

    // Probe a register on both I and D sides; latency 10000 never collides with a reservation.
    task automatic look(input int r);
        sb_if.inst_val_Ihl    = 1'b1;
        sb_if.src0            = 5'(r);
        sb_if.src0_en         = 1'b1;
        sb_if.dst_en          = 1'b0;
        sb_if.func_unit       = '0;
        sb_if.latency         = 5'b10000;
        sb_if.inst_val_Dhl    = 1'b1;
        sb_if.src0_byp_Dhl    = 5'(r);
        sb_if.src0_byp_en_Dhl = 1'b1;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2;
        expect_eq("rst_sel0", sb_if.src0_byp_mux_sel, 0);
        expect_eq("rst_sel1", sb_if.src1_byp_mux_sel, 0);
        expect_eq("rst_wbsel", sb_if.wb_mux_sel, 0);
        expect_eq("rst_stallI_noval", sb_if.stall_hazard_Ihl, 1);
        expect_eq("rst_stallD_noval", sb_if.stall_hazard_Dhl, 1);
        sb_if.inst_val_Ihl = 1'b1;
        sb_if.inst_val_Dhl = 1'b1;
        sb_if.latency      = 5'b00100;
        #1;
        expect_eq("rst_stallI_val", sb_if.stall_hazard_Ihl, 0);
        expect_eq("rst_stallD_val", sb_if.stall_hazard_Dhl, 0);
        idle();
        tick();
        reset = 1'b0;
        tick();

        // ALU r3, latency 00100, slot 2
        issue(3, FU_ALU, 5'b00100, 2);
        #1;
        expect_eq("t1_accept", sb_if.stall_hazard_Ihl, 0);
        tick();
        idle(); look(3);
        #1;
        expect_eq("t1_lat4_stallI", sb_if.stall_hazard_Ihl, 1);
        expect_eq("t1_lat4_stallD", sb_if.stall_hazard_Dhl, 1);
        expect_eq("t1_lat4_sel", sb_if.src0_byp_mux_sel, 1);
        expect_eq("t1_slot", sb_if.src0_byp_rob_slot, 2);
        expect_eq("t1_lat4_wbsel", sb_if.wb_mux_sel, 0);
        tick();
        expect_eq("t1_lat2_stallI", sb_if.stall_hazard_Ihl, 0);
        expect_eq("t1_lat2_stallD", sb_if.stall_hazard_Dhl, 0);
        expect_eq("t1_lat2_sel", sb_if.src0_byp_mux_sel, 1);
        expect_eq("t1_lat2_wbsel", sb_if.wb_mux_sel, 1);
        tick();
        expect_eq("t1_lat1_sel_wb", sb_if.src0_byp_mux_sel, 4);
        expect_eq("t1_lat1_wbsel", sb_if.wb_mux_sel, 0);
        tick();
        expect_eq("t1_lat0_sel_rob", sb_if.src0_byp_mux_sel, 5);
        sb_if.rob_commit_wen  = 1'b1;
        sb_if.rob_commit_slot = 4'd2;
        tick();
        expect_eq("t1_commit_sel", sb_if.src0_byp_mux_sel, 0);
        drain(4);

        // MUL r5, latency 10000: I-side stalls until latency drops below bit 2
        issue(5, FU_MUL, 5'b10000, 4);
        tick();
        idle(); look(5);
        #1;
        expect_eq("t2_l16_stallI", sb_if.stall_hazard_Ihl, 1);
        expect_eq("t2_l16_sel", sb_if.src0_byp_mux_sel, 3);
        tick();
        expect_eq("t2_l8_stallI", sb_if.stall_hazard_Ihl, 1);
        tick();
        expect_eq("t2_l4_stallI", sb_if.stall_hazard_Ihl, 1);
        tick();
        expect_eq("t2_l2_stallI", sb_if.stall_hazard_Ihl, 0);
        drain(4);

        // MEM r7 latency 00100, then ALU r8 latency 00010 collides on writeback
        issue(7, FU_MEM, 5'b00100, 5);
        tick();
        idle();
        issue(8, FU_ALU, 5'b00010, 6);
        sb_if.stalls          = 5'b00100;
        sb_if.inst_val_Dhl    = 1'b1;
        sb_if.src0_byp_Dhl    = 5'd7;
        sb_if.src0_byp_en_Dhl = 1'b1;
        #1;
        expect_eq("t3_conflict", sb_if.stall_hazard_Ihl, 1);
        expect_eq("t3_mem_sel", sb_if.src0_byp_mux_sel, 2);
        tick();
        expect_eq("t3_frozen_conflict", sb_if.stall_hazard_Ihl, 1);
        expect_eq("t3_frozen_wbsel", sb_if.wb_mux_sel, 0);
        sb_if.stalls = '0;
        tick();
        expect_eq("t3_clear_accept", sb_if.stall_hazard_Ihl, 0);
        expect_eq("t3_mem_wbsel", sb_if.wb_mux_sel, 2);
        tick();
        expect_eq("t3_alu_wbsel", sb_if.wb_mux_sel, 1);
        sb_if.src1_byp_Dhl    = 5'd8;
        sb_if.src1_byp_en_Dhl = 1'b1;
        #1;
        expect_eq("t3_r8_sel", sb_if.src1_byp_mux_sel, 1);
        drain(5);

        // Commit of r9's slot clears pending; re-accept in the same cycle wins
        issue(9, FU_ALU, 5'b00010, 7);
        tick();
        idle();
        sb_if.src0_byp_Dhl    = 5'd9;
        sb_if.src0_byp_en_Dhl = 1'b1;
        #1;
        expect_eq("t4_sel_before", sb_if.src0_byp_mux_sel, 1);
        expect_eq("t4_slot_before", sb_if.src0_byp_rob_slot, 7);
        sb_if.rob_commit_wen  = 1'b1;
        sb_if.rob_commit_slot = 4'd7;
        tick();
        expect_eq("t4_commit_sel", sb_if.src0_byp_mux_sel, 0);
        issue(9, FU_MEM, 5'b00100, 3);
        #1;
        expect_eq("t4_reaccept", sb_if.stall_hazard_Ihl, 0);
        tick();
        expect_eq("t4_reaccept_sel", sb_if.src0_byp_mux_sel, 2);
        expect_eq("t4_reaccept_slot", sb_if.src0_byp_rob_slot, 3);
        idle();
        sb_if.src0_byp_Dhl    = 5'd9;
        sb_if.src0_byp_en_Dhl = 1'b1;
        sb_if.rob_commit_wen  = 1'b1;
        sb_if.rob_commit_slot = 4'd7;
        tick();
        expect_eq("t4_stale_commit", sb_if.src0_byp_mux_sel, 2);
        sb_if.rob_commit_slot = 4'd3;
        tick();
        expect_eq("t4_new_commit", sb_if.src0_byp_mux_sel, 0);
        drain(4);

        // Asynchronous reset mid-flight
        issue(11, FU_ALU, 5'b01000, 1);
        tick();
        idle(); look(11);
        #1;
        expect_eq("t5_pre_stallI", sb_if.stall_hazard_Ihl, 1);
        expect_eq("t5_pre_sel", sb_if.src0_byp_mux_sel, 1);
        #2;
        reset = 1'b1;
        #1;
        expect_eq("t5_rst_sel", sb_if.src0_byp_mux_sel, 0);
        expect_eq("t5_rst_stallI", sb_if.stall_hazard_Ihl, 0);
        expect_eq("t5_rst_stallD", sb_if.stall_hazard_Dhl, 0);
        expect_eq("t5_rst_wbsel", sb_if.wb_mux_sel, 0);
        idle();
        tick();
        reset = 1'b0;
        drain(2);

`ifdef PARC_SB_FLUSH_EN
        // Flush with three producers pending
        issue(12, FU_MUL, 5'b10000, 8);
        tick();
        issue(13, FU_MUL, 5'b10000, 9);
        tick();
        issue(14, FU_MUL, 5'b10000, 10);
        tick();
        issue(15, FU_ALU, 5'b00100, 11);
        sb_if.flush = 1'b1;
        #1;
        expect_eq("t6_flush_noaccept", sb_if.stall_hazard_Ihl, 1);
        tick();
        idle();
        sb_if.src0_byp_Dhl    = 5'd12;
        sb_if.src0_byp_en_Dhl = 1'b1;
        sb_if.src1_byp_Dhl    = 5'd13;
        sb_if.src1_byp_en_Dhl = 1'b1;
        #1;
        expect_eq("t6_r12_sel", sb_if.src0_byp_mux_sel, 0);
        expect_eq("t6_r13_sel", sb_if.src1_byp_mux_sel, 0);
        expect_eq("t6_wbsel", sb_if.wb_mux_sel, 0);
        idle(); look(14);
        #1;
        expect_eq("t6_r14_stallI", sb_if.stall_hazard_Ihl, 0);
        sb_if.src0_byp_Dhl = 5'd15;
        #1;
        expect_eq("t6_r15_sel", sb_if.src0_byp_mux_sel, 0);
        drain(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
